alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Instruction issue and writeback sequencer sitting directly upstream of the pro_unit register-file/ALU datapath. Accepts 32-bit instruction words over a valid/ready stream, buffers them in a small FIFO, decodes each into register-file read addresses and an ALU opcode, and captures the 64-bit ALU result. It optionally writes the low 32 bits back into the register file and returns the full result on a valid/ready response stream. One instruction is in flight at a time, so no operand hazards exist.

## Interface
- FIFO_DEPTH, 4, instruction FIFO entries; power of two, minimum 2
- clk  in  1  single clock; all state on rising edge
- clr_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  instruction word valid
- in_ready  out  1  FIFO can accept; equals !full
- in_instr  in  32  instruction word
- alu_op  out  4  to pro_unit alu_op
- readreg1 / readreg2  out  5 each  to pro_unit read addresses
- writereg  out  5  to pro_unit write address
- wr_op  out  1  to pro_unit write enable
- data_in  out  32  to pro_unit write data
- alu_out  in  64  from pro_unit out
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  64  result
- res_err  out  1  instruction had a reserved opclass
- retired_cnt  out  32  present only with ISSUE_PERF_CNT_EN

## Operation
- Instruction fields: [31:30] opclass (00 ALU, 01 LOADI, 10/11 reserved).
- ALU fields: [29:26] alu_op, [25:21] rd, [20:16] rs1, [15:11] rs2, [10] wb_en.
- LOADI fields: [25:21] rd, [15:0] imm, zero-extended to 32 bits.
- FSM states: IDLE, READ, EXEC, WB, RESP.
  - IDLE → READ when FIFO non-empty; the head entry is popped on this edge.
  - READ → EXEC unconditionally. readreg1/readreg2/alu_op are registered and stable throughout READ and EXEC.
  - EXEC → WB. res_data is captured from alu_out on this edge.
- WB behaviour by opclass:
  - ALU: wr_op=1 for exactly this cycle if wb_en, with writereg=rd and data_in=alu_out[31:0]. The register file samples on the falling edge inside WB.
  - LOADI: skips the ALU. wr_op=1 with data_in=imm; res_data={32'b0, imm}.
  - Reserved: no register-file write; res_data=0, res_err=1.
- WB → RESP.
- RESP: res_valid=1; res_data and res_err are held until res_valid && res_ready.
  - On handshake, go to READ if FIFO non-empty (popping the head), else IDLE.
- wr_op is 0 in every state except WB. Addresses and data_in hold their last values outside WB.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready is low when full, even if a pop occurs in the same cycle.
  - A pop and push in the same cycle on a non-full FIFO are both honoured.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: in_ready=1, all address/op/data outputs 0, wr_op=0, res_valid=0, res_data=0, res_err=0, retired_cnt=0, FSM=IDLE, FIFO empty.
- Reset mid-operation: asserting clr_n low immediately clears wr_op and res_valid and discards FIFO contents and any in-flight instruction.
- Latency, FIFO empty: push at edge E → READ after E+1, EXEC after E+2, WB after E+3, res_valid high after E+4.
- Minimum issue interval: 4 cycles per instruction (RESP → READ back-to-back when res_ready is high).
- res_ready low stalls the FSM in RESP; the FIFO continues to accept until full.

## Configuration
- ISSUE_PERF_CNT_EN defined: retired_cnt port exists. It increments by 1 on each response handshake, including error results, and wraps 0xFFFFFFFF → 0.
- ISSUE_PERF_CNT_EN undefined: the port and counter logic are absent.

## Structure
- alu_issue_pkg holds:
  - opclass enum
  - FSM state enum
  - instruction field bit-position localparams
  - ALU opcode constants matching the pro_unit encoding
- Sub-module issue_fifo: parameterised synchronous FIFO with push/pop/full/empty ports, instantiated once.

## Test plan
- After reset, push LOADI rd=3 imm=0x0040, then ALU add (alu_op=0) rd=5 rs1=3 rs2=3 wb_en=1 → res_data=0x40, then 0x80; register 5 reads 0x80; wr_op high exactly one cycle per instruction.
- Push ALU sub with wb_en=0 after loading r1=10, r2=3 → res_data=7; wr_op never asserted during that instruction.
- Hold res_ready=0 and push 5 instructions with FIFO_DEPTH=4 → in_ready drops after the FIFO fills; release res_ready → all 5 results arrive in order, each 4 cycles apart.
- Push opclass 2'b10 → res_err=1, res_data=0, no wr_op; the next valid instruction executes normally with res_err=0.
- Pull clr_n low during WB of a queued sequence → wr_op=0 and res_valid=0 asynchronously; after release, in_ready=1, FIFO empty, no stale result.
- With ISSUE_PERF_CNT_EN defined, retire 3 instructions (one of them an error) → retired_cnt=3.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue/writeback sequencer:
// instruction opclasses, FSM states, instruction field positions and the
// pro_unit ALU opcode encoding.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        OPC_ALU   = 2'b00,
        OPC_LOADI = 2'b01,
        OPC_RSV2  = 2'b10,
        OPC_RSV3  = 2'b11
    } opclass_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_WB   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    localparam int OPC_HI    = 31;
    localparam int OPC_LO    = 30;
    localparam int ALUOP_HI  = 29;
    localparam int ALUOP_LO  = 26;
    localparam int RD_HI     = 25;
    localparam int RD_LO     = 21;
    localparam int RS1_HI    = 20;
    localparam int RS1_LO    = 16;
    localparam int RS2_HI    = 15;
    localparam int RS2_LO    = 11;
    localparam int WBEN_BIT  = 10;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    // pro_unit ALU opcodes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_MUL = 4'd7;

    function automatic opclass_e get_opclass(input logic [31:0] instr);
        return opclass_e'(instr[OPC_HI:OPC_LO]);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction stream, response stream and pro_unit
// register-file/ALU connections of the issue sequencer.
// slave: the sequencer side; master: the environment side.
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [3:0]  alu_op;
    logic [4:0]  readreg1;
    logic [4:0]  readreg2;
    logic [4:0]  writereg;
    logic        wr_op;
    logic [31:0] data_in;
    logic [63:0] alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_err;

    modport slave (
        input  in_valid, in_instr, alu_out, res_ready,
        output in_ready, alu_op, readreg1, readreg2, writereg, wr_op,
               data_in, res_valid, res_data, res_err
    );

    modport master (
        output in_valid, in_instr, alu_out, res_ready,
        input  in_ready, alu_op, readreg1, readreg2, writereg, wr_op,
               data_in, res_valid, res_data, res_err
    );
endinterface

// File: rtl/issue_fifo.sv
// Synchronous instruction FIFO. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally. full is driven from occupancy only, so a pop in
// the same cycle does not make room for a push.
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // next pointers, occupancy and storage write
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Instruction issue and writeback sequencer in front of pro_unit.
// Optional feature macro: ISSUE_PERF_CNT_EN adds the retired_cnt output
// (count of response handshakes, wrapping).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no instruction in flight, waiting for the FIFO to fill
// READ    | read addresses / alu_op presented to the register file
// EXEC    | ALU evaluating; result captured on the exit edge
// WB      | register-file write (wr_op) for ALU+wb_en and LOADI
// RESP    | res_valid held until the consumer takes the result
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    alu_issue_ctrl_if.slave  bus
`ifdef ISSUE_PERF_CNT_EN
   ,output logic [31:0]      retired_cnt
`endif
);
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0] fifo_rdata;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [4:0]  writereg_q, writereg_d;
    logic [31:0] data_in_q, data_in_d;
    logic        wr_op_q, wr_op_d;
    logic [63:0] res_data_q, res_data_d;
    logic        res_err_q, res_err_d;
    logic        resp_hs;
    opclass_e    opc;
    logic [15:0] imm;

    assign fifo_push = bus.in_valid && !fifo_full;
    assign resp_hs   = (state_q == ST_RESP) && bus.res_ready;
    assign opc       = get_opclass(instr_q);
    assign imm       = instr_q[IMM_HI:IMM_LO];

    issue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .clr_n (clr_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.in_instr),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, FIFO pop, result capture and writeback setup
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        writereg_d = writereg_q;
        data_in_d  = data_in_q;
        wr_op_d    = 1'b0;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    instr_d  = fifo_rdata;
                    state_d  = ST_READ;
                end
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_WB;
                unique case (opc)
                    OPC_ALU: begin
                        res_data_d = bus.alu_out;
                        res_err_d  = 1'b0;
                        if (instr_q[WBEN_BIT]) begin
                            wr_op_d    = 1'b1;
                            writereg_d = instr_q[RD_HI:RD_LO];
                            data_in_d  = bus.alu_out[31:0];
                        end
                    end
                    OPC_LOADI: begin
                        res_data_d = {48'b0, imm};
                        res_err_d  = 1'b0;
                        wr_op_d    = 1'b1;
                        writereg_d = instr_q[RD_HI:RD_LO];
                        data_in_d  = {16'b0, imm};
                    end
                    default: begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                    end
                endcase
            end
            ST_WB: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.res_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        instr_d  = fifo_rdata;
                        state_d  = ST_READ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            writereg_q <= '0;
            data_in_q  <= '0;
            wr_op_q    <= 1'b0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            writereg_q <= writereg_d;
            data_in_q  <= data_in_d;
            wr_op_q    <= wr_op_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.alu_op    = instr_q[ALUOP_HI:ALUOP_LO];
    assign bus.readreg1  = instr_q[RS1_HI:RS1_LO];
    assign bus.readreg2  = instr_q[RS2_HI:RS2_LO];
    assign bus.writereg  = writereg_q;
    assign bus.wr_op     = wr_op_q;
    assign bus.data_in   = data_in_q;
    assign bus.res_valid = (state_q == ST_RESP);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;

    // Count every accepted response, error results included
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (resp_hs) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
        end
    end

    // Retired-instruction counter register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            retired_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural pro_unit model
// and an expected-result queue filled at issue time.
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        logic        wr;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus();
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
`ifdef ISSUE_PERF_CNT_EN
       ,.retired_cnt (retired_cnt)
`endif
    );

    function automatic logic [63:0] pro_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ALU_ADD: return {32'b0, a} + {32'b0, b};
            ALU_SUB: return {32'b0, a} - {32'b0, b};
            ALU_AND: return {32'b0, a & b};
            ALU_OR:  return {32'b0, a | b};
            ALU_XOR: return {32'b0, a ^ b};
            ALU_SLL: return {32'b0, a << b[4:0]};
            ALU_SRL: return {32'b0, a >> b[4:0]};
            ALU_MUL: return {32'b0, a} * {32'b0, b};
            default: return 64'd0;
        endcase
    endfunction

    // pro_unit model: combinational ALU, register file written on falling edge
    logic [31:0] regs [32] = '{default: 32'd0};
    int wr_cnt = 0;
    int cyc = 0;
    always_comb bus.alu_out = pro_alu(bus.alu_op, regs[bus.readreg1], regs[bus.readreg2]);
    always @(negedge clk) begin
        if (bus.wr_op) begin
            regs[bus.writereg] <= bus.data_in;
            wr_cnt <= wr_cnt + 1;
        end
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    logic [31:0] sh [32];
    int wr_base = 0;
    int hs_cnt = 0;
    int hs_cyc = 0;
    int gap = 0;
    int valid_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_alu(input logic [3:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic wb);
        return {2'b00, op, rd, rs1, rs2, wb, 10'b0};
    endfunction

    function automatic logic [31:0] mk_loadi(input logic [4:0] rd, input logic [15:0] imm);
        return {2'b01, 4'b0, rd, 5'b0, imm};
    endfunction

    task automatic send(input logic [31:0] instr);
        exp_t e;
        logic [63:0] r;
        int n;
        e = '0;
        case (instr[31:30])
            2'b00: begin
                r = pro_alu(instr[29:26], sh[instr[20:16]], sh[instr[15:11]]);
                e.data = r;
                e.wr   = instr[10];
                if (instr[10]) sh[instr[25:21]] = r[31:0];
            end
            2'b01: begin
                e.data = {48'b0, instr[15:0]};
                e.wr   = 1'b1;
                sh[instr[25:21]] = {16'b0, instr[15:0]};
            end
            default: begin
                e.data = 64'd0;
                e.err  = 1'b1;
            end
        endcase
        sb.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) check("push_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int n;
        n = 0;
        while (!bus.res_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.res_valid) begin
            check({tag, "_timeout"}, {63'd0, bus.res_valid}, 64'd1);
            return;
        end
        valid_cyc = cyc;
        if (sb.size() == 0) begin
            check({tag, "_unexpected"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, bus.res_data, e.data);
            check({tag, "_err"}, {63'd0, bus.res_err}, {63'd0, e.err});
            check({tag, "_wrcnt"}, 64'(wr_cnt - wr_base), {63'd0, e.wr});
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        gap = cyc - hs_cyc;
        hs_cyc = cyc;
        wr_base = wr_cnt;
        hs_cnt++;
    endtask

    initial begin
        int t0;
        int n;
        int seen;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 32; i++) sh[i] = 32'd0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_wr_op", {63'd0, bus.wr_op}, 64'd0);
        check("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
        check("rst_res_data", bus.res_data, 64'd0);
        check("rst_res_err", {63'd0, bus.res_err}, 64'd0);
        check("rst_addr", {47'd0, bus.alu_op, bus.readreg1, bus.readreg2, bus.writereg}, 64'd0);
        check("rst_data_in", {32'd0, bus.data_in}, 64'd0);
        clr_n = 1'b1;
        @(posedge clk); #1;
        wr_base = wr_cnt;

        // LOADI then dependent ADD with writeback; first result latency
        send(mk_loadi(5'd3, 16'h0040));
        t0 = cyc;
        collect("loadi_r3");
        check("latency", 64'(valid_cyc - t0), 64'd4);
        send(mk_alu(ALU_ADD, 5'd5, 5'd3, 5'd3, 1'b1));
        collect("add_r5");
        check("reg5", {32'd0, regs[5]}, 64'h80);

        // SUB without writeback
        send(mk_loadi(5'd1, 16'd10));
        send(mk_loadi(5'd2, 16'd3));
        send(mk_alu(ALU_SUB, 5'd6, 5'd1, 5'd2, 1'b0));
        collect("loadi_r1");
        collect("loadi_r2");
        collect("sub_nowb");

        // stall with res_ready low: FIFO fills, then drains every 4 cycles
        send(mk_alu(ALU_ADD, 5'd10, 5'd1, 5'd2, 1'b1));
        send(mk_alu(ALU_AND, 5'd11, 5'd1, 5'd2, 1'b1));
        send(mk_alu(ALU_XOR, 5'd12, 5'd10, 5'd11, 1'b1));
        send(mk_alu(ALU_MUL, 5'd13, 5'd12, 5'd10, 1'b0));
        send(mk_loadi(5'd14, 16'hBEEF));
        check("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        collect("stall0");
        for (int k = 1; k < 5; k++) begin
            collect($sformatf("stall%0d", k));
            check($sformatf("gap%0d", k), 64'(gap), 64'd4);
        end
        check("drained_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // reserved opclass followed by a normal instruction
        send({2'b10, 30'h0ABCDEF});
        send(mk_loadi(5'd8, 16'h1234));
        collect("reserved");
        collect("after_reserved");

        // wide 64-bit product
        send(mk_loadi(5'd15, 16'hFFFF));
        send(mk_loadi(5'd17, 16'd16));
        send(mk_alu(ALU_SLL, 5'd16, 5'd15, 5'd17, 1'b1));
        send(mk_alu(ALU_MUL, 5'd18, 5'd16, 5'd16, 1'b1));
        for (int k = 0; k < 4; k++) collect($sformatf("wide%0d", k));

        // asynchronous reset during WB
        send(mk_loadi(5'd20, 16'h0055));
        send(mk_loadi(5'd21, 16'h0066));
        n = 0;
        while (!bus.wr_op && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_wb", {63'd0, bus.wr_op}, 64'd1);
        clr_n = 1'b0;
        #1;
        check("async_wr_op", {63'd0, bus.wr_op}, 64'd0);
        check("async_res_valid", {63'd0, bus.res_valid}, 64'd0);
        sb.delete();
        @(posedge clk); #1;
        clr_n = 1'b1;
        @(posedge clk); #1;
        sh = regs;
        wr_base = wr_cnt;
        hs_cnt = 0;
        check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("post_rst_res_data", bus.res_data, 64'd0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.res_valid || bus.wr_op) seen++;
            @(posedge clk); #1;
        end
        check("no_stale", 64'(seen), 64'd0);
        check("no_stale_write", 64'(wr_cnt - wr_base), 64'd0);
        check("reg20_untouched", {32'd0, regs[20]}, 64'd0);

        // three retirements after reset, one of them an error
        send(mk_alu(ALU_ADD, 5'd9, 5'd3, 5'd5, 1'b1));
        send({2'b11, 30'h1});
        send(mk_loadi(5'd22, 16'h7777));
        collect("ret0");
        collect("ret1");
        collect("ret2");
        check("reg9", {32'd0, regs[9]}, 64'hC0);
`ifdef ISSUE_PERF_CNT_EN
        check("retired_cnt", {32'd0, retired_cnt}, 64'd3);
`endif
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
